cpu_datapath: RTL and testbench

Phase-1 32-bit CPU datapath: sixteen general registers, PC, HI/LO, Y, 64-bit Z, MAR, MDR and an in-port register, all sharing one 32-bit bus selected by one-hot "out" strobes. The ALU takes operand A from Y and operand B from the bus. It writes a 64-bit result to Z. The control unit does not exist yet, so every register enable, bus strobe and the ALU opcode are driven directly from ports.

---
 rtl/cpu_datapath.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_datapath.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Phase-1 32-bit CPU datapath: register file, special registers, single shared bus
// and a 64-bit-result ALU, all steered directly from port-level strobes and enables.
module cpu_datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        PCin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Yin,
    input  logic        MARin,
    input  logic        InPortIn,
    input  logic        Zin,
    input  logic        MDRin,
    input  logic        read,
    input  logic        incPC,
    input  logic [4:0]  opcode,
    input  logic [31:0] Mdatain,
    input  logic        R0out,
    input  logic        R1out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        R8out,
    input  logic        R9out,
    input  logic        R10out,
    input  logic        R11out,
    input  logic        R12out,
    input  logic        R13out,
    input  logic        R14out,
    input  logic        R15out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        ZHighOut,
    input  logic        ZLowOut,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        InPortOut,
    output logic [31:0] BusMuxOut,
    output logic [31:0] mar_out
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

    logic [15:0] r_in;
    logic [15:0] r_out;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    logic [31:0] r_q [16];
    logic [31:0] r_d [16];
    logic [31:0] pc_q, pc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] y_q, y_d;
    logic [63:0] z_q, z_d;
    logic [31:0] mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] inport_q, inport_d;

    logic [31:0] bus;

    // Later assignments override earlier ones, so sources are listed lowest priority first.
    always_comb begin
        bus = 32'h0;
        if (InPortOut) bus = inport_q;
        if (MDRout)    bus = mdr_q;
        if (PCout)     bus = pc_q;
        if (ZLowOut)   bus = z_q[31:0];
        if (ZHighOut)  bus = z_q[63:32];
        if (LOout)     bus = lo_q;
        if (HIout)     bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) bus = r_q[i];
        end
    end

    assign BusMuxOut = bus;
    assign mar_out   = mar_q;   // feeds the memory address port once memory is attached

    logic [31:0]        alu_a, alu_b;
    logic [4:0]         sh;
    logic signed [31:0] a_s, b_s;
    logic signed [63:0] a_ext, b_ext, prod;
    logic [31:0]        res_lo, res_hi;

    assign alu_a = y_q;
    assign alu_b = bus;
    assign sh    = alu_b[4:0];
    assign a_s   = alu_a;
    assign b_s   = alu_b;
    assign a_ext = {{32{alu_a[31]}}, alu_a};
    assign b_ext = {{32{alu_b[31]}}, alu_b};
    assign prod  = a_ext * b_ext;

    always_comb begin
        res_lo = 32'h0;
        res_hi = 32'h0;
        case (opcode)
            OP_ADD:  res_lo = alu_a + alu_b;
            OP_SUB:  res_lo = alu_a - alu_b;
            OP_SHR:  res_lo = alu_a >> sh;
            OP_SHRA: res_lo = a_s >>> sh;
            OP_SHL:  res_lo = alu_a << sh;
            OP_ROR:  res_lo = (alu_a >> sh) | (alu_a << (6'd32 - {1'b0, sh}));
            OP_ROL:  res_lo = (alu_a << sh) | (alu_a >> (6'd32 - {1'b0, sh}));
            OP_AND:  res_lo = alu_a & alu_b;
            OP_OR:   res_lo = alu_a | alu_b;
            OP_MUL: begin
                res_lo = prod[31:0];
                res_hi = prod[63:32];
            end
            OP_DIV: begin
                // Zero divisor and the single overflowing pair get defined results.
                if (alu_b == 32'h0) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = alu_a;
                end else if (alu_a == 32'h8000_0000 && alu_b == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'h0;
                end else begin
                    res_lo = a_s / b_s;
                    res_hi = a_s % b_s;
                end
            end
            OP_NEG:  res_lo = 32'd0 - alu_b;
            OP_NOT:  res_lo = ~alu_b;
            default: begin
                res_lo = 32'h0;
                res_hi = 32'h0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            r_d[i] = r_in[i] ? bus : r_q[i];
        end
        pc_d = pc_q;
        if (PCin)       pc_d = bus;
        else if (incPC) pc_d = pc_q + 32'd1;
        hi_d     = HIin     ? bus : hi_q;
        lo_d     = LOin     ? bus : lo_q;
        y_d      = Yin      ? bus : y_q;
        mar_d    = MARin    ? bus : mar_q;
        inport_d = InPortIn ? bus : inport_q;
        z_d      = Zin      ? {res_hi, res_lo} : z_q;
        mdr_d    = mdr_q;
        if (MDRin) mdr_d = read ? Mdatain : bus;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= 32'h0;
            end
            pc_q     <= 32'h0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            y_q      <= 32'h0;
            z_q      <= 64'h0;
            mar_q    <= 32'h0;
            mdr_q    <= 32'h0;
            inport_q <= 32'h0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= r_d[i];
            end
            pc_q     <= pc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            y_q      <= y_d;
            z_q      <= z_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            inport_q <= inport_d;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: drivers issue bus observations and push the
// hand-computed value; a negedge monitor pops and compares against BusMuxOut.
module tb_cpu_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] r_in, r_out;
    logic        PCin, HIin, LOin, Yin, MARin, InPortIn, Zin, MDRin, read, incPC;
    logic [4:0]  opcode;
    logic [31:0] Mdatain;
    logic        HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut;
    logic [31:0] BusMuxOut, mar_out;

    logic        obs_valid;
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mon_exp;
    string       mon_name;

    always #5 clock = ~clock;

    cpu_datapath dut (
        .clock(clock), .clear(clear),
        .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
        .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
        .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .PCin(PCin), .HIin(HIin), .LOin(LOin), .Yin(Yin), .MARin(MARin),
        .InPortIn(InPortIn), .Zin(Zin), .MDRin(MDRin), .read(read), .incPC(incPC),
        .opcode(opcode), .Mdatain(Mdatain),
        .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
        .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
        .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut),
        .PCout(PCout), .MDRout(MDRout), .InPortOut(InPortOut),
        .BusMuxOut(BusMuxOut), .mar_out(mar_out)
    );

    // Monitor: compares the bus mid-cycle whenever a driver has flagged an observation.
    always @(negedge clock) begin
        if (obs_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_obs: got %08h with empty expected queue", BusMuxOut);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (BusMuxOut !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got %08h expected %08h", mon_name, BusMuxOut, mon_exp);
                end
            end
        end
    end

    task automatic clear_ctrl();
        r_in = '0; r_out = '0;
        PCin = 0; HIin = 0; LOin = 0; Yin = 0; MARin = 0; InPortIn = 0;
        Zin = 0; MDRin = 0; read = 0; incPC = 0; opcode = '0; Mdatain = '0;
        HIout = 0; LOout = 0; ZHighOut = 0; ZLowOut = 0; PCout = 0;
        MDRout = 0; InPortOut = 0;
        obs_valid = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clear_ctrl();
    endtask

    task automatic expect_bus(input string nm, input logic [31:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
        obs_valid = 1;
        tick();
    endtask

    task automatic load_reg(input int r, input logic [31:0] v);
        Mdatain = v; read = 1; MDRin = 1;
        tick();
        MDRout = 1; r_in[r] = 1;
        tick();
    endtask

    task automatic chk_reg(input string nm, input int r, input logic [31:0] v);
        r_out[r] = 1;
        expect_bus(nm, v);
    endtask

    task automatic alu_run(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [31:0] hi, input logic [31:0] lo);
        load_reg(1, a);
        load_reg(2, b);
        r_out[1] = 1; Yin = 1;
        tick();
        r_out[2] = 1; opcode = op; Zin = 1;
        tick();
        ZLowOut = 1;
        expect_bus({nm, "_lo"}, lo);
        ZHighOut = 1;
        expect_bus({nm, "_hi"}, hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ctrl();
        clear = 0;
        // Everything enabled while in reset: nothing may load.
        r_in = '1; MDRin = 1; read = 1; Mdatain = 32'hDEAD_BEEF; PCin = 1; incPC = 1;
        Zin = 1; Yin = 1; HIin = 1; LOin = 1; InPortIn = 1; MARin = 1; opcode = 5'b10001;
        repeat (3) @(posedge clock);
        #1;
        r_out[0] = 1;
        expect_bus("rst_bus", 32'h0);
        clear = 1;
        chk_reg("rst_r0", 0, 32'h0);
        chk_reg("rst_r9", 9, 32'h0);
        chk_reg("rst_r15", 15, 32'h0);
        MDRout = 1;    expect_bus("rst_mdr", 32'h0);
        PCout = 1;     expect_bus("rst_pc", 32'h0);
        HIout = 1;     expect_bus("rst_hi", 32'h0);
        LOout = 1;     expect_bus("rst_lo", 32'h0);
        ZLowOut = 1;   expect_bus("rst_zlo", 32'h0);
        ZHighOut = 1;  expect_bus("rst_zhi", 32'h0);
        InPortOut = 1; expect_bus("rst_inport", 32'h0);

        // Divide sequence from memory through to HI/LO.
        load_reg(2, 32'd30);
        load_reg(6, 32'd25);
        r_out[2] = 1; Yin = 1; tick();
        r_out[6] = 1; opcode = 5'b01111; Zin = 1; tick();
        ZLowOut = 1; LOin = 1; tick();
        ZHighOut = 1; HIin = 1; tick();
        LOout = 1; expect_bus("div_lo_reg", 32'd1);
        HIout = 1; expect_bus("div_hi_reg", 32'd5);

        alu_run("div_neg",  32'hFFFF_FFF9, 32'd2,        5'b01111, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        alu_run("div_zero", 32'd9,         32'd0,        5'b01111, 32'd9,         32'hFFFF_FFFF);
        alu_run("div_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 5'b01111, 32'h0,        32'h8000_0000);
        alu_run("mul_neg",  32'hFFFF_FFFD, 32'd5,        5'b01110, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        alu_run("mul_big",  32'h0001_0000, 32'h0001_0000, 5'b01110, 32'h1,        32'h0);
        alu_run("add_wrap", 32'hFFFF_FFFF, 32'd1,        5'b00011, 32'h0,         32'h0);
        alu_run("sub",      32'd5,         32'd7,        5'b00100, 32'h0,         32'hFFFF_FFFE);
        alu_run("shr",      32'h8000_0000, 32'd4,        5'b00101, 32'h0,         32'h0800_0000);
        alu_run("shra",     32'h8000_0000, 32'd4,        5'b00110, 32'h0,         32'hF800_0000);
        alu_run("shl",      32'd1,         32'd4,        5'b00111, 32'h0,         32'h10);
        alu_run("ror",      32'd1,         32'd1,        5'b01000, 32'h0,         32'h8000_0000);
        alu_run("rol",      32'h8000_0000, 32'd1,        5'b01001, 32'h0,         32'h1);
        alu_run("and",      32'hF0F0,      32'hFF00,     5'b01010, 32'h0,         32'hF000);
        alu_run("or",       32'hF0F0,      32'hFF00,     5'b01011, 32'h0,         32'hFFF0);
        alu_run("neg",      32'd3,         32'd5,        5'b10000, 32'h0,         32'hFFFF_FFFB);
        alu_run("not",      32'd3,         32'd0,        5'b10001, 32'h0,         32'hFFFF_FFFF);
        alu_run("mul_pre",  32'd7,         32'hFFFF_FFFF, 5'b01110, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        alu_run("bad_op",   32'd7,         32'd9,        5'b00000, 32'h0,         32'h0);

        // PC increment wrap and PCin priority.
        load_reg(3, 32'hFFFF_FFFF);
        r_out[3] = 1; PCin = 1; tick();
        incPC = 1; tick();
        PCout = 1; expect_bus("pc_wrap", 32'h0);
        incPC = 1; tick();
        PCout = 1; expect_bus("pc_inc", 32'h1);
        load_reg(3, 32'hA5A5_0000);
        r_out[3] = 1; PCin = 1; incPC = 1; tick();
        PCout = 1; expect_bus("pc_load_wins", 32'hA5A5_0000);

        // Bus priority and multi-destination loads.
        load_reg(3, 32'h33);
        load_reg(5, 32'h55);
        r_out[3] = 1; r_out[5] = 1; expect_bus("prio_r3_r5", 32'h33);
        r_out[5] = 1; HIout = 1;    expect_bus("prio_r5_hi", 32'h55);
        r_out[3] = 1; InPortIn = 1; MARin = 1; tick();
        InPortOut = 1; expect_bus("inport", 32'h33);
        MDRout = 1; InPortOut = 1; expect_bus("prio_mdr_inport", 32'h55);
        expect_bus("bus_idle", 32'h0);
        MDRout = 1; r_in[7] = 1; r_in[8] = 1; tick();
        chk_reg("multi_r7", 7, 32'h55);
        chk_reg("multi_r8", 8, 32'h55);
        r_out[0] = 1; expect_bus("r0_not_hardwired", 32'h0);
        load_reg(0, 32'h1234_5678);
        chk_reg("r0_load", 0, 32'h1234_5678);

        // Asynchronous clear between edges.
        load_reg(4, 32'h1234);
        #2;
        clear = 0;
        #1;
        r_out[4] = 1;
        expect_bus("async_clr", 32'h0);
        clear = 1;
        chk_reg("r4_after_clr", 4, 32'h0);
        MDRout = 1; expect_bus("mdr_after_clr", 32'h0);
        PCout = 1;  expect_bus("pc_after_clr", 32'h0);

        tick();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_exp: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
